// File: rtl/spi_ram_burst.sv
// Command-decoding SPI RAM: 2-bit opcode words set addresses, write data and
// launch reads; read data returns through a READ_LAT-deep pipeline with a tx handshake.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int READ_LAT  = 1,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              addr_err,
  output logic              addr_wrap
);

  localparam logic [1:0] OP_SET_WR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RD = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [DATA_W:0]   DEPTH_LIM = (DATA_W + 1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              payload_ok;
  logic              rd_accept;
  logic              wr_last;
  logic              rd_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;

  // Stage READ_LAT-1 of the read pipeline is the output register (dout/tx_valid).
  logic [DATA_W-1:0] stg_d [READ_LAT];
  logic              stg_v [READ_LAT];
  logic [DATA_W-1:0] in_d  [READ_LAT];
  logic              in_v  [READ_LAT];

  // Handshakes: a word moves on an edge where valid && ready are both high.
  // rx: at most one read is in flight, so rx_ready drops from read acceptance
  // until the tx transfer edge. tx: once tx_valid rises, dout and tx_valid hold
  // until the edge with tx_ready high.
  assign opcode     = din[DATA_W+1:DATA_W];
  assign payload    = din[DATA_W-1:0];
  assign rx_ready   = !busy;
  assign accept     = rx_valid && !busy;
  assign payload_ok = {1'b0, payload} < DEPTH_LIM;
  assign rd_accept  = accept && (opcode == OP_READ);
  assign wr_last    = (wr_addr == LAST_ADDR);
  assign rd_last    = (rd_addr == LAST_ADDR);

  assign dout     = stg_d[READ_LAT-1];
  assign tx_valid = stg_v[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (accept && (opcode == OP_WRITE)) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      addr_err  <= 1'b0;
      addr_wrap <= 1'b0;
    end else begin
      addr_err  <= 1'b0;
      addr_wrap <= 1'b0;
      if (accept) begin
        case (opcode)
          OP_SET_WR: begin
            if (payload_ok) wr_addr <= payload[ADDR_W-1:0];
            else            addr_err <= 1'b1;
          end
          OP_SET_RD: begin
            if (payload_ok) rd_addr <= payload[ADDR_W-1:0];
            else            addr_err <= 1'b1;
          end
          OP_WRITE: begin
            if (AUTO_INC) begin
              wr_addr   <= wr_last ? '0 : wr_addr + ADDR_W'(1);
              addr_wrap <= wr_last;
            end
          end
          default: begin
            if (AUTO_INC) begin
              rd_addr   <= rd_last ? '0 : rd_addr + ADDR_W'(1);
              addr_wrap <= rd_last;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (rd_accept) begin
      busy <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      busy <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < READ_LAT; i++) begin
      in_d[i] = '0;
      in_v[i] = 1'b0;
    end
    in_d[0] = mem[rd_addr];
    in_v[0] = rd_accept;
    for (int i = 1; i < READ_LAT; i++) begin
      in_d[i] = stg_d[i-1];
      in_v[i] = stg_v[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stg_d[i] <= '0;
        stg_v[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < READ_LAT; i++) begin
        if (i == READ_LAT - 1) begin
          // Output stage: hold while stalled, dout keeps its value after transfer.
          if (stg_v[i]) begin
            if (tx_ready) stg_v[i] <= 1'b0;
          end else begin
            stg_v[i] <= in_v[i];
            if (in_v[i]) stg_d[i] <= in_d[i];
          end
        end else begin
          stg_v[i] <= in_v[i];
          if (in_v[i]) stg_d[i] <= in_d[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Randomized bench for spi_ram_burst against an array/queue reference model;
// a second instance covers the non-incrementing, 3-deep read configuration.
module tb_spi_ram_burst;

  localparam int DW    = 8;
  localparam int DEPTH = 200;
  localparam int LAT   = 2;
  localparam int LAT_B = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [DW+1:0] din = '0;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          addr_err;
  logic          addr_wrap;

  logic          b_rx_valid = 1'b0;
  logic          b_rx_ready;
  logic [DW+1:0] b_din = '0;
  logic [DW-1:0] b_dout;
  logic          b_tx_valid;
  logic          b_addr_err;
  logic          b_addr_wrap;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory contents and the two address pointers.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wr = 0;
  int            m_rd = 0;
  logic [DW-1:0] exp_q [$];

  spi_ram_burst #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .READ_LAT(LAT), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready), .din(din),
    .dout(dout), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addr_err(addr_err), .addr_wrap(addr_wrap)
  );

  spi_ram_burst #(.DATA_W(DW), .MEM_DEPTH(256), .READ_LAT(LAT_B), .AUTO_INC(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .din(b_din),
    .dout(b_dout), .tx_valid(b_tx_valid), .tx_ready(1'b1),
    .addr_err(b_addr_err), .addr_wrap(b_addr_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Non-read command on the main instance; checks the event pulses and their clear.
  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] pl);
    logic exp_err;
    logic exp_wrap;
    @(negedge clk);
    rx_valid = 1'b1;
    din = {op, pl};
    chk("rx_ready_idle", rx_ready, 1);
    exp_err = 1'b0;
    exp_wrap = 1'b0;
    case (op)
      2'b00: if (int'(pl) < DEPTH) m_wr = int'(pl); else exp_err = 1'b1;
      2'b10: if (int'(pl) < DEPTH) m_rd = int'(pl); else exp_err = 1'b1;
      default: begin
        m_mem[m_wr] = pl;
        exp_wrap = (m_wr == DEPTH - 1);
        m_wr = (m_wr + 1) % DEPTH;
      end
    endcase
    @(negedge clk);
    rx_valid = 1'b0;
    chk("addr_err", addr_err, exp_err);
    chk("addr_wrap", addr_wrap, exp_wrap);
    @(negedge clk);
    chk("pulses_clear", {addr_err, addr_wrap}, 0);
  endtask

  // Read with `hold` cycles of tx backpressure once the word is presented.
  task automatic do_read(input int hold);
    logic          exp_wrap;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    tx_ready = (hold == 0);
    rx_valid = 1'b1;
    din = {2'b11, DW'($urandom)};
    chk("rx_ready_rd", rx_ready, 1);
    exp_q.push_back(m_mem[m_rd]);
    exp_wrap = (m_rd == DEPTH - 1);
    m_rd = (m_rd + 1) % DEPTH;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rx_valid = 1'b0;
        chk("rd_wrap", addr_wrap, exp_wrap);
      end
      if (k == 2) chk("rd_wrap_clr", addr_wrap, 0);
      chk("rx_ready_busy", rx_ready, 0);
      chk("tx_valid_lat", tx_valid, (k == LAT));
    end
    exp_d = exp_q.pop_front();
    chk("dout", dout, exp_d);
    for (int h = 0; h < hold; h++) begin
      rx_valid = 1'b1;
      din = {2'b01, 8'hEE};
      @(negedge clk);
      chk("hold_valid", tx_valid, 1);
      chk("hold_dout", dout, exp_d);
      chk("hold_rx_ready", rx_ready, 0);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_done", tx_valid, 0);
    chk("rx_ready_after", rx_ready, 1);
    chk("dout_kept", dout, exp_d);
  endtask

  task automatic b_cmd(input logic [1:0] op, input logic [DW-1:0] pl);
    @(negedge clk);
    b_rx_valid = 1'b1;
    b_din = {op, pl};
    @(negedge clk);
    b_rx_valid = 1'b0;
    chk("b_wrap", b_addr_wrap, 0);
  endtask

  task automatic b_read(input logic [DW-1:0] exp_d);
    @(negedge clk);
    b_rx_valid = 1'b1;
    b_din = {2'b11, 8'h00};
    chk("b_rx_ready", b_rx_ready, 1);
    for (int k = 1; k <= LAT_B; k++) begin
      @(negedge clk);
      b_rx_valid = 1'b0;
      chk("b_tx_valid_lat", b_tx_valid, (k == LAT_B));
    end
    chk("b_dout", b_dout, exp_d);
    chk("b_rd_wrap", b_addr_wrap, 0);
    @(negedge clk);
    chk("b_tx_done", b_tx_valid, 0);
  endtask

  initial begin
    int r;
    logic [DW-1:0] saved;
    // Reset state
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_pulses", {addr_err, addr_wrap}, 0);
    chk("rst_b_tx_valid", b_tx_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill every word; the last write wraps the write pointer.
    send_cmd(2'b00, 8'h00);
    for (int i = 0; i < DEPTH; i++) send_cmd(2'b01, DW'($urandom));

    // Directed: write/read round trip
    send_cmd(2'b00, 8'h10);
    send_cmd(2'b01, 8'hA5);
    send_cmd(2'b10, 8'h10);
    do_read(0);

    // Burst across the top of memory
    send_cmd(2'b00, 8'(DEPTH - 2));
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b01, 8'h22);
    send_cmd(2'b01, 8'h33);
    send_cmd(2'b10, 8'(DEPTH - 2));
    do_read(0);
    do_read(0);
    do_read(0);

    // Backpressure with ignored commands, then verify memory unaffected
    send_cmd(2'b10, 8'h40);
    do_read(5);
    send_cmd(2'b10, 8'h40);
    do_read(0);
    do_read(0);

    // Out-of-range address commands
    send_cmd(2'b00, 8'h30);
    send_cmd(2'b00, 8'(DEPTH));
    send_cmd(2'b01, 8'h5A);
    send_cmd(2'b00, 8'(DEPTH - 1));
    send_cmd(2'b10, 8'hFF);
    send_cmd(2'b10, 8'h30);
    do_read(0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      send_cmd(2'b00, DW'($urandom_range(0, 255)));
      else if (r < 5) send_cmd(2'b01, DW'($urandom));
      else if (r < 7) send_cmd(2'b10, DW'($urandom_range(0, 255)));
      else            do_read($urandom_range(0, 3));
    end

    // Reset one cycle after a read is accepted
    @(negedge clk);
    rx_valid = 1'b1;
    din = {2'b11, 8'h00};
    @(negedge clk);
    din = {2'b00, 8'h05};
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
    chk("mid_rst_dout", dout, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    m_wr = 0;
    m_rd = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("post_rst_tx_valid", tx_valid, 0);
      chk("post_rst_rx_ready", rx_ready, 1);
    end
    do_read(0);
    do_read(0);
    send_cmd(2'b10, 8'h30);
    do_read(0);
    send_cmd(2'b01, 8'h6C);
    send_cmd(2'b10, 8'h00);
    do_read(0);

    // Non-incrementing instance with three-deep read pipeline
    b_cmd(2'b00, 8'h20);
    b_cmd(2'b01, 8'h3C);
    b_cmd(2'b10, 8'h20);
    b_read(8'h3C);
    b_read(8'h3C);
    b_cmd(2'b01, 8'h77);
    b_read(8'h77);
    saved = 8'hAB;
    b_cmd(2'b00, 8'hFF);
    b_cmd(2'b01, 8'h99);
    b_cmd(2'b01, saved);
    b_cmd(2'b10, 8'hFF);
    b_read(saved);
    b_cmd(2'b10, 8'h20);
    b_read(8'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
